memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 124 ++++++++++++
 tb/tb_memory_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Wait-stated single-port 32-bit memory slave with IDLE/WAIT/DONE handshake.
// Optional write protection of the low address range under `WRITE_PROTECT_EN.
//
// state  | meaning
// S_IDLE | no access outstanding, Read/Write sampled
// S_WAIT | counting wait states for the latched access
// S_DONE | access completed this cycle, Done pulsed
module memory_responder #(
  parameter int ADDR_WIDTH    = 9,
  parameter int WAIT_CYCLES   = 2,
  parameter int PROTECT_LIMIT = 63
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [ADDR_WIDTH-1:0] MAR_Addr,
  input  logic [31:0]           MDR_Data,
  input  logic                  Read,
  input  logic                  Write,
  output logic [31:0]           MData_Out,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] PROT_LIM = ADDR_WIDTH'(PROTECT_LIMIT);
`ifdef WRITE_PROTECT_EN
  localparam bit WP_ENABLE = 1'b1;
`else
  localparam bit WP_ENABLE = 1'b0;
`endif

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  write_q;

  logic                  accept, conflict, enter_done;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [31:0]           data_sel;
  logic                  op_write, wp_hit, commit_write, commit_read;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  assign accept   = (state == S_IDLE) && (Read ^ Write);
  assign conflict = (state == S_IDLE) && Read && Write;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_done = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_nxt  = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        Busy    = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A zero-wait access completes on its accepting edge, before the latches hold it.
  assign addr_sel = (state == S_IDLE) ? MAR_Addr : addr_q;
  assign data_sel = (state == S_IDLE) ? MDR_Data : data_q;
  assign op_write = (state == S_IDLE) ? Write    : write_q;

  assign wp_hit       = WP_ENABLE && op_write && (addr_sel <= PROT_LIM);
  assign commit_write = enter_done && op_write && !wp_hit;
  assign commit_read  = enter_done && !op_write;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      MData_Out <= '0;
      Err       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= MAR_Addr;
        data_q  <= MDR_Data;
        write_q <= Write;
      end
      if (commit_read)
        MData_Out <= mem[addr_sel];
      Err <= conflict || (enter_done && wp_hit);
    end
  end

  // Storage is deliberately outside the reset domain so contents survive Clear.
  always_ff @(posedge Clock) begin
    if (commit_write)
      mem[addr_sel] <= data_sel;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: a 2-wait-state and a 0-wait-state responder share stimulus,
// each checked against its own timing/memory reference model.
module tb_memory_responder;

  localparam int AW = 9;
`ifdef WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          done;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Clear = 1'b0;
  logic [AW-1:0] MAR_Addr = '0;
  logic [31:0]   MDR_Data = '0;
  logic          Read = 1'b0;
  logic          Write = 1'b0;
  logic [31:0]   mdo0, mdo1;
  logic          busy0, busy1, done0, done1, err0, err1;

  memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2), .PROTECT_LIMIT(63)) dut0 (
    .Clock(Clock), .Clear(Clear), .MAR_Addr(MAR_Addr), .MDR_Data(MDR_Data),
    .Read(Read), .Write(Write), .MData_Out(mdo0), .Busy(busy0), .Done(done0), .Err(err0));

  memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0), .PROTECT_LIMIT(63)) dut1 (
    .Clock(Clock), .Clear(Clear), .MAR_Addr(MAR_Addr), .MDR_Data(MDR_Data),
    .Read(Read), .Write(Write), .MData_Out(mdo1), .Busy(busy1), .Done(done1), .Err(err1));

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state, per responder
  exp_t        expq [2][$];
  logic [31:0] mmem [2][1<<AW];
  bit          mval [2][1<<AW];
  int          free_at [2];
  int          last_acc [2];
  bit          pend_v [2];
  int          pend_a [2];
  int          pend_due [2];
  logic [31:0] pend_d [2];
  logic [31:0] last_rd [2];
  bit          last_rd_k [2];

  function automatic int wc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h want %h", name, d, cyc, act, exp);
    end
  endfunction

  function automatic void settle(int d, int upto);
    if (pend_v[d] && pend_due[d] <= upto) begin
      mmem[d][pend_a[d]] = pend_d[d];
      mval[d][pend_a[d]] = 1'b1;
      pend_v[d] = 1'b0;
    end
  endfunction

  function automatic void model_reset(int d);
    settle(d, cyc);
    pend_v[d]    = 1'b0;
    free_at[d]   = 0;
    last_acc[d]  = -100;
    expq[d].delete();
    last_rd[d]   = '0;
    last_rd_k[d] = 1'b1;
  endfunction

  // Request presented for sampling at edge k.
  function automatic void model_issue(int d, int k, bit rd, bit wr, int a, logic [31:0] dat);
    exp_t e;
    if (k < free_at[d] || !(rd || wr)) return;
    settle(d, k - 1);
    if (rd && wr) begin
      e = '{due: k, done: 1'b0, err: 1'b1, chk: 1'b0, data: '0};
      expq[d].push_back(e);
      return;
    end
    last_acc[d] = k;
    free_at[d]  = k + wc(d) + 2;
    e.due  = k + wc(d);
    e.done = 1'b1;
    if (wr) begin
      e.err  = WP && (a <= 63);
      e.chk  = last_rd_k[d];
      e.data = last_rd[d];
      if (!e.err) begin
        pend_v[d] = 1'b1; pend_a[d] = a; pend_d[d] = dat; pend_due[d] = e.due;
      end
    end else begin
      e.err  = 1'b0;
      e.chk  = mval[d][a];
      e.data = mmem[d][a];
      last_rd[d]   = mmem[d][a];
      last_rd_k[d] = mval[d][a];
    end
    expq[d].push_back(e);
  endfunction

  function automatic void monitor(int d, logic dn, logic er, logic bz, logic [31:0] mdo);
    exp_t e;
    chk("busy", d, 32'(bz), 32'((cyc >= last_acc[d]) && (cyc <= last_acc[d] + wc(d))));
    if (dn || er) begin
      if (expq[d].size() == 0) begin
        chk("unexpected_done_err", d, {30'd0, dn, er}, 32'd0);
      end else begin
        e = expq[d].pop_front();
        chk("resp_cycle", d, cyc, e.due);
        chk("done", d, 32'(dn), 32'(e.done));
        chk("err", d, 32'(er), 32'(e.err));
        if (e.chk) chk("mdata", d, mdo, e.data);
      end
    end else if (expq[d].size() != 0 && expq[d][0].due <= cyc) begin
      e = expq[d].pop_front();
      chk("missing_resp_at", d, cyc, e.due);
    end
  endfunction

  always @(negedge Clock) begin
    monitor(0, done0, err0, busy0, mdo0);
    monitor(1, done1, err1, busy1, mdo1);
  end

  task automatic drive(bit rd, bit wr, logic [AW-1:0] a, logic [31:0] dat);
    @(negedge Clock);
    #1;
    Read = rd; Write = wr; MAR_Addr = a; MDR_Data = dat;
    for (int d = 0; d < 2; d++) model_issue(d, cyc + 1, rd, wr, int'(a), dat);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_at[0] || cyc + 1 < free_at[1]) drive(0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    #1;
    Clear = 1'b0; Read = 1'b0; Write = 1'b0;
    #1;
    chk("rst_busy", 0, 32'(busy0), 0); chk("rst_done", 0, 32'(done0), 0);
    chk("rst_err", 0, 32'(err0), 0);   chk("rst_mdata", 0, mdo0, 0);
    chk("rst_busy", 1, 32'(busy1), 0); chk("rst_done", 1, 32'(done1), 0);
    chk("rst_err", 1, 32'(err1), 0);   chk("rst_mdata", 1, mdo1, 0);
    model_reset(0);
    model_reset(1);
    @(negedge Clock);
    #1;
    Clear = 1'b1;
  endtask

  initial begin
    int r;
    logic [AW-1:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < (1<<AW); i++) begin mmem[d][i] = '0; mval[d][i] = 1'b0; end
      model_reset(d);
    end
    do_reset();

    // write then read back
    drive(0, 1, 9'h080, 32'hDEADBEEF); drive(0, 0, '0, '0); wait_idle();
    drive(1, 0, 9'h080, 32'h0);        drive(0, 0, '0, '0); wait_idle();
    drive(0, 1, 9'h001, 32'h12345678); drive(0, 0, '0, '0); wait_idle();
    drive(1, 0, 9'h001, 32'h0);        drive(0, 0, '0, '0); wait_idle();
    // conflicting request, then confirm memory untouched
    drive(1, 1, 9'h080, 32'h0BADF00D); drive(0, 0, '0, '0); wait_idle();
    drive(1, 0, 9'h080, 32'h0);        drive(0, 0, '0, '0); wait_idle();
    // second read pulse while the first is still outstanding
    drive(1, 0, 9'h001, 32'h0); drive(1, 0, 9'h080, 32'h0); drive(0, 0, '0, '0); wait_idle();
    // reset during the wait of a write
    drive(0, 1, 9'h0AA, 32'h11); drive(0, 0, '0, '0); wait_idle();
    drive(0, 1, 9'h0AA, 32'h5);  drive(0, 0, '0, '0);
    do_reset();
    drive(1, 0, 9'h0AA, 32'h0); drive(0, 0, '0, '0); wait_idle();
    // low-region write, protected only when the feature is built in
    drive(0, 1, 9'h010, 32'hFFFFFFFF); drive(0, 0, '0, '0); wait_idle();
    drive(1, 0, 9'h010, 32'h0);        drive(0, 0, '0, '0); wait_idle();

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        r = int'($urandom_range(0, 9));
        a = AW'($urandom_range(0, 15) * 32 + $urandom_range(0, 1));
        drive(r == 0 || (r >= 1 && r <= 3), r == 0 || (r >= 4 && r <= 6), a, $urandom);
      end
    end
    drive(0, 0, '0, '0);
    wait_idle();
    repeat (3) drive(0, 0, '0, '0);
    chk("drain", 0, 32'(expq[0].size()), 0);
    chk("drain", 1, 32'(expq[1].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
